// File: rtl/vga_timing_regfile.sv
// VGA timing register bank: three 60 Hz presets plus a custom mode, committed to the active set at a frame boundary.
// Latency: with a commit pending, Load_config pulses the cycle after Frame_end and the outputs change one cycle after that.
// Backpressure: Rdy is low while a commit is pending or loading; writes inside the window then pulse Err and are dropped.
module vga_timing_regfile #(
    parameter int CONFIG_WIDTH = 16,
    parameter int CNT_W = 11,
    parameter int PULSE_W = 8,
    parameter int MARGIN_W = 8,
    parameter logic [CONFIG_WIDTH-1:0] ADDR_BASE = 'h10,
    parameter bit SYNC_ON_FRAME = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Valid,
    input  logic [CONFIG_WIDTH-1:0] Addr,
    input  logic [CONFIG_WIDTH-1:0] Data,
    input  logic                    Frame_end,
    output logic                    Rdy,
    output logic                    Err,
    output logic                    Load_config,
    output logic [1:0]              Mode,
    output logic [CNT_W-1:0]        H_count_max,
    output logic [CNT_W-1:0]        V_count_max,
    output logic [PULSE_W-1:0]      H_sync_pulse,
    output logic [PULSE_W-1:0]      V_sync_pulse,
    output logic [MARGIN_W-1:0]     H_left_margin,
    output logic [MARGIN_W-1:0]     H_right_margin,
    output logic [MARGIN_W-1:0]     V_left_margin,
    output logic [MARGIN_W-1:0]     V_right_margin
);

    typedef struct packed {
        logic [CNT_W-1:0]    hmax;
        logic [CNT_W-1:0]    vmax;
        logic [PULSE_W-1:0]  hs;
        logic [PULSE_W-1:0]  vs;
        logic [MARGIN_W-1:0] hl;
        logic [MARGIN_W-1:0] hr;
        logic [MARGIN_W-1:0] vl;
        logic [MARGIN_W-1:0] vr;
    } timing_t;

    typedef enum logic [1:0] {IDLE, PEND, LOAD} state_t;

    localparam logic [1:0] MODE_CUSTOM = 2'd3;

    function automatic timing_t preset(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd1: t = '{hmax: CNT_W'(1055), vmax: CNT_W'(627), hs: PULSE_W'(128), vs: PULSE_W'(4),
                        hl: MARGIN_W'(88), hr: MARGIN_W'(40), vl: MARGIN_W'(23), vr: MARGIN_W'(1)};
            2'd2: t = '{hmax: CNT_W'(1343), vmax: CNT_W'(805), hs: PULSE_W'(136), vs: PULSE_W'(6),
                        hl: MARGIN_W'(160), hr: MARGIN_W'(24), vl: MARGIN_W'(29), vr: MARGIN_W'(3)};
            default: t = '{hmax: CNT_W'(799), vmax: CNT_W'(524), hs: PULSE_W'(96), vs: PULSE_W'(2),
                           hl: MARGIN_W'(48), hr: MARGIN_W'(16), vl: MARGIN_W'(33), vr: MARGIN_W'(10)};
        endcase
        return t;
    endfunction

    state_t                  state;
    timing_t                 act;
    timing_t                 stg;
    logic [1:0]              stg_mode;
    logic                    err_hold;
    logic [CONFIG_WIDTH-1:0] off;
    logic [3:0]              off4;
    logic                    in_win;
    logic [CNT_W+1:0]        h_sum;
    logic [CNT_W+1:0]        v_sum;
    logic                    cfg_ok;
    logic                    leave_pend;

    // Addresses below the base wrap to large offsets, so one compare bounds the window.
    assign off    = Addr - ADDR_BASE;
    assign off4   = off[3:0];
    assign in_win = off < CONFIG_WIDTH'(10);

    // Porch + sync must fit inside the line/frame total; only custom settings can violate this.
    assign h_sum  = (CNT_W+2)'(stg.hs) + (CNT_W+2)'(stg.hl) + (CNT_W+2)'(stg.hr);
    assign v_sum  = (CNT_W+2)'(stg.vs) + (CNT_W+2)'(stg.vl) + (CNT_W+2)'(stg.vr);
    assign cfg_ok = (stg_mode != MODE_CUSTOM) ||
                    ((h_sum < (CNT_W+2)'(stg.hmax)) && (v_sum < (CNT_W+2)'(stg.vmax)));
    assign leave_pend = SYNC_ON_FRAME ? Frame_end : 1'b1;

    assign H_count_max    = act.hmax;
    assign V_count_max    = act.vmax;
    assign H_sync_pulse   = act.hs;
    assign V_sync_pulse   = act.vs;
    assign H_left_margin  = act.hl;
    assign H_right_margin = act.hr;
    assign V_left_margin  = act.vl;
    assign V_right_margin = act.vr;

    // Staging/commit FSM with registered Rdy, Err and Load_config pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            Rdy         <= 1'b1;
            Err         <= 1'b0;
            err_hold    <= 1'b0;
            Load_config <= 1'b1;
            act         <= preset(2'd0);
            stg         <= preset(2'd0);
            Mode        <= 2'd0;
            stg_mode    <= 2'd0;
        end else begin
            Err         <= 1'b0;
            Load_config <= 1'b0;
            case (state)
                IDLE: begin
                    if (Valid && in_win) begin
                        case (off4)
                            4'd0: begin
                                if (Data < CONFIG_WIDTH'(3)) begin
                                    stg      <= preset(Data[1:0]);
                                    stg_mode <= Data[1:0];
                                    state    <= PEND;
                                    Rdy      <= 1'b0;
                                end else if (Data == CONFIG_WIDTH'(3)) begin
                                    stg_mode <= MODE_CUSTOM;
                                    state    <= PEND;
                                    Rdy      <= 1'b0;
                                end else begin
                                    Err <= 1'b1;
                                end
                            end
                            4'd1: begin stg.hmax <= CNT_W'(Data);    stg_mode <= MODE_CUSTOM; end
                            4'd2: begin stg.vmax <= CNT_W'(Data);    stg_mode <= MODE_CUSTOM; end
                            4'd3: begin stg.hs   <= PULSE_W'(Data);  stg_mode <= MODE_CUSTOM; end
                            4'd4: begin stg.vs   <= PULSE_W'(Data);  stg_mode <= MODE_CUSTOM; end
                            4'd5: begin stg.hl   <= MARGIN_W'(Data); stg_mode <= MODE_CUSTOM; end
                            4'd6: begin stg.hr   <= MARGIN_W'(Data); stg_mode <= MODE_CUSTOM; end
                            4'd7: begin stg.vl   <= MARGIN_W'(Data); stg_mode <= MODE_CUSTOM; end
                            4'd8: begin stg.vr   <= MARGIN_W'(Data); stg_mode <= MODE_CUSTOM; end
                            4'd9: begin
                                state <= PEND;
                                Rdy   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                PEND: begin
                    if (leave_pend) begin
                        if (cfg_ok) begin
                            state       <= LOAD;
                            Load_config <= 1'b1;
                            // A write rejected now is reported after the load pulse, never alongside it.
                            err_hold    <= Valid && in_win;
                        end else begin
                            state    <= IDLE;
                            Rdy      <= 1'b1;
                            Err      <= 1'b1;
                            stg      <= act;
                            stg_mode <= Mode;
                        end
                    end else begin
                        Err <= Valid && in_win;
                    end
                end
                LOAD: begin
                    act      <= stg;
                    Mode     <= stg_mode;
                    state    <= IDLE;
                    Rdy      <= 1'b1;
                    Err      <= err_hold || (Valid && in_win);
                    err_hold <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Rdy   <= 1'b1;
                end
            endcase
        end
    end

endmodule
